// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t ADJ_THRESH = 4'd5;
   localparam bcd_digit_t ADJ_ADD    = 4'd3;

   // Decimal capacity of n BCD digits, used for the elaboration-time size check.
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_in,
   input  bcd_digit_t digit_out_unused_guard,
   output bcd_digit_t digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= ADJ_THRESH) begin
         digit_out = bcd_digit_t'(digit_in + ADJ_ADD);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a valid/ready handshake on both sides.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      binary_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam longint unsigned MAX_IN  = (64'd1 << BIN_W) - 64'd1;
   localparam longint unsigned DEC_CAP = pow10(DIGITS);

   if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
      $error("bin2bcd_seq: BIN_W must be within 4..32");
   end
   if (DEC_CAP <= MAX_IN) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small to hold 2**BIN_W-1");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   acc_q, acc_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               out_valid_q, out_valid_d;
   logic [BCD_W-1:0]   acc_adj;

   // Per-digit add-3 correction applied before every shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_in              (acc_q[4*g +: 4]),
         .digit_out_unused_guard(4'd0),
         .digit_out             (acc_adj[4*g +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_d   = binary_in;
               acc_d   = '0;
               cnt_d   = CNT_W'(BIN_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, bin_d} = {acc_adj, bin_q} << 1;
            cnt_d          = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = acc_d;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status flags are registered from the next state so they track state_q.
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d == SHIFT);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bin_q       <= '0;
         acc_q       <= '0;
         bcd_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bin_q       <= bin_d;
         acc_q       <= acc_d;
         bcd_q       <= bcd_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq at 8/3 and 16/5 configurations.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;

   logic [7:0]  binary_in;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [11:0] bcd_out;

   logic [15:0] b16_in;
   logic        b16_in_valid, b16_in_ready, b16_out_valid, b16_out_ready, b16_busy;
   logic [19:0] b16_bcd;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
      .clk(clk), .rst(rst), .binary_in(binary_in), .in_valid(in_valid),
      .in_ready(in_ready), .bcd_out(bcd_out), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
      .clk(clk), .rst(rst), .binary_in(b16_in), .in_valid(b16_in_valid),
      .in_ready(b16_in_ready), .bcd_out(b16_bcd), .out_valid(b16_out_valid),
      .out_ready(b16_out_ready), .busy(b16_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal reference via division, independent of the shift-and-add method.
   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      r = '0;
      for (int d = 0; d < 8; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic conv8(input logic [7:0] v, input logic [11:0] exp, input string tag);
      int lat;
      for (int i = 0; i < 30 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      binary_in = v;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'd8);
      check_eq({tag, " bcd"}, 32'(bcd_out), 32'(exp));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, " ov_clear"}, 32'(out_valid), 32'd0);
   endtask

   task automatic conv16(input logic [15:0] v, input logic [19:0] exp, input string tag);
      int lat;
      for (int i = 0; i < 40 && !b16_in_ready; i++) begin
         @(posedge clk); #1;
      end
      b16_in       = v;
      b16_in_valid = 1'b1;
      @(posedge clk); #1;
      b16_in_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         lat++;
         if (b16_out_valid) break;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'd16);
      check_eq({tag, " bcd"}, 32'(b16_bcd), 32'(exp));
      b16_out_ready = 1'b1;
      @(posedge clk); #1;
      b16_out_ready = 1'b0;
      check_eq({tag, " ov_clear"}, 32'(b16_out_valid), 32'd0);
   endtask

   initial begin
      logic [7:0]  bb_val [3];
      logic [11:0] bb_exp [3];
      int          acc_t  [3];
      int          k, r;
      bit          acc_now;

      rst = 1'b1;
      binary_in = '0; in_valid = 1'b0; out_ready = 1'b0;
      b16_in = '0; b16_in_valid = 1'b0; b16_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst in_ready", 32'(in_ready), 32'd1);
      check_eq("rst out_valid", 32'(out_valid), 32'd0);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst bcd", 32'(bcd_out), 32'd0);
      check_eq("rst16 in_ready", 32'(b16_in_ready), 32'd1);
      rst = 1'b0;

      // First acceptance directly after reset release, value zero.
      conv8(8'd0, 12'h000, "zero");

      conv8(8'd202, 12'h202, "v202");
      conv8(8'd255, 12'h255, "v255");
      conv8(8'd9,   12'h009, "v9");
      conv8(8'd10,  12'h010, "v10");
      conv8(8'd199, 12'h199, "v199");

      for (int v = 0; v < 256; v++) begin
         conv8(8'(v), 12'(to_bcd(v)), $sformatf("sweep%0d", v));
      end

      // Backpressure: result held while out_ready is low; new input ignored.
      binary_in = 8'd99; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("bp busy", 32'(busy), 32'd1);
      for (int i = 0; i < 30 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            binary_in = 8'd7;
            in_valid  = 1'b1;
         end
         @(posedge clk); #1;
         check_eq("bp out_valid", 32'(out_valid), 32'd1);
         check_eq("bp bcd", 32'(bcd_out), 32'h099);
         check_eq("bp in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("bp idle in_ready", 32'(in_ready), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      check_eq("bp retained bcd", 32'(bcd_out), 32'h099);
      check_eq("bp no extra result", 32'(out_valid), 32'd0);
      check_eq("bp no extra busy", 32'(busy), 32'd0);

      // Reset pulsed on the 4th SHIFT cycle of a conversion.
      binary_in = 8'd128; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("mid busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("mid rst out_valid", 32'(out_valid), 32'd0);
      check_eq("mid rst bcd", 32'(bcd_out), 32'd0);
      check_eq("mid rst in_ready", 32'(in_ready), 32'd1);
      check_eq("mid rst busy", 32'(busy), 32'd0);
      #2;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_eq("mid no partial", 32'(out_valid), 32'd0);
      check_eq("mid bcd still 0", 32'(bcd_out), 32'd0);
      conv8(8'd45, 12'h045, "after_rst45");

      // Back-to-back with in_valid and out_ready held high.
      bb_val[0] = 8'd17;  bb_exp[0] = 12'h017;
      bb_val[1] = 8'd200; bb_exp[1] = 12'h200;
      bb_val[2] = 8'd63;  bb_exp[2] = 12'h063;
      k = 0; r = 0;
      binary_in = bb_val[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 80 && r < 3; c++) begin
         acc_now = in_ready && in_valid;
         @(posedge clk); #1;
         if (acc_now) begin
            acc_t[k] = c;
            k++;
            if (k < 3) binary_in = bb_val[k];
            else in_valid = 1'b0;
         end
         if (out_valid && r < 3) begin
            check_eq($sformatf("b2b bcd%0d", r), 32'(bcd_out), 32'(bb_exp[r]));
            r++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_eq("b2b accepts", 32'(k), 32'd3);
      check_eq("b2b results", 32'(r), 32'd3);
      if (k == 3) begin
         check_eq("b2b gap01", 32'(acc_t[1] - acc_t[0]), 32'd10);
         check_eq("b2b gap12", 32'(acc_t[2] - acc_t[1]), 32'd10);
      end

      // Wide configuration.
      conv16(16'd65535, 20'h65535, "w65535");
      conv16(16'd10000, 20'h10000, "w10000");
      conv16(16'd1234,  20'h01234, "w1234");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary input width in bits (legal range 4..32).
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits; elaboration SHALL fail if 10**DIGITS <= 2**BIN_W - 1.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port binary_in  input  BIN_W  unsigned value to convert.
REQ-006 SHALL have port in_valid  input  1  binary_in is valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a new value.
REQ-008 SHALL have port bcd_out  output  4*DIGITS  packed BCD result, most-significant digit in the top nibble.
REQ-009 SHALL have port out_valid  output  1  bcd_out holds a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts bcd_out.
REQ-011 SHALL have port busy  output  1  a conversion is in progress (state SHIFT).

Function
REQ-012 SHALL convert with the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock.
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 IDLE: in_ready=1; on in_valid=1, SHALL capture binary_in, clear the BCD accumulator, load bit counter=BIN_W, and go to SHIFT.
REQ-015 SHIFT: each cycle SHALL add 3 to every accumulator digit >=5, then shift {accumulator, binary shift register} left by 1, and decrement the counter.
REQ-016 SHIFT: when counter equals 1 at a clock edge, SHALL perform the final step and go to DONE.
REQ-017 Latency SHALL be exactly BIN_W cycles: out_valid rises BIN_W rising edges after the accepting edge.
REQ-018 DONE: out_valid=1 and bcd_out stable; on out_ready=1, SHALL go to IDLE with out_valid=0 on the following cycle.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; changes on binary_in and in_valid there SHALL be ignored.
REQ-020 bcd_out SHALL retain the last result in IDLE until the next acceptance; only out_valid qualifies it.
REQ-021 Every output digit SHALL be in range 0..9 for all inputs; the maximum 2**BIN_W-1 SHALL convert without truncation.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Back-to-back: minimum spacing between acceptances SHALL be BIN_W+2 cycles (accept, BIN_W shifts, one DONE handshake).

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, bcd_out=0, out_valid=0, busy=0, in_ready=1, counter=0, and shift registers=0.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the conversion with no partial result presented afterwards.
REQ-026 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Package bcd_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), the bcd_digit_t 4-bit typedef, and the ADJ_THRESH=5 / ADJ_ADD=3 constants.
REQ-028 Sub-module bcd_digit_adjust (combinational, 4-bit in/out, add 3 if >=5) SHALL be instantiated DIGITS times by a generate loop.
REQ-029 All state SHALL be held in a single always_ff block with async reset; next-state and adjust logic SHALL be combinational.

Verification
REQ-030 Defaults, binary_in=0 accepted -> out_valid after 8 cycles, bcd_out=12'h000.
REQ-031 Defaults, sweep 0..255 with out_ready=1 -> each bcd_out equals the decimal digits (e.g. 202 -> 12'h202, 255 -> 12'h255); each latency is exactly 8.
REQ-032 Backpressure: 99 accepted, out_ready held 0 for 5 cycles -> out_valid stays 1, bcd_out=12'h099 stable, in_ready=0, and a new in_valid is ignored.
REQ-033 Reset mid-conversion: 128 accepted, rst pulsed on the 4th SHIFT cycle -> out_valid=0, bcd_out=0, in_ready=1; a following 45 yields 12'h045.
REQ-034 BIN_W=16, DIGITS=5: 65535 -> 20'h65535 after 16 cycles; 10000 -> 20'h10000.
REQ-035 Back-to-back with in_valid held 1 and out_ready=1 -> acceptances exactly 10 cycles apart at defaults, results in order.
